// File: rtl/frame_uart_streamer_if.sv
// Streamer-side bundle: control, BRAM read port and uart_tx byte handshake.
// The streamer uses the master modport; its environment uses the slave modport.
interface frame_uart_streamer_if #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 19
);
  logic              start;
  logic [1:0]        mode;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [7:0]        tx_data;
  logic              start_tx;
  logic              tx_busy;

  modport master (
    input  start, mode, abort, rd_data, tx_busy,
    output busy, done, rd_req, rd_addr, tx_data, start_tx
  );

  modport slave (
    output start, mode, abort, rd_data, tx_busy,
    input  busy, done, rd_req, rd_addr, tx_data, start_tx
  );
endinterface

// File: rtl/frame_uart_streamer.sv
// Streams a BRAM frame buffer to uart_tx as HDR0, HDR1, mode byte, then packed pixels.
// Define FRAME_UART_STREAMER_CHECKSUM_EN to append an XOR-of-payload trailer byte.
module frame_uart_streamer #(
  parameter int         PIX_W  = 12,
  parameter int         ADDR_W = 19,
  parameter int         DEPTH  = 76800,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A
) (
  input  logic                  clk,
  input  logic                  rst_db,
  frame_uart_streamer_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start, rd_addr parked at 0
  // HDR   | sending HDR0, HDR1 and the mode byte
  // FETCH | reading one pixel (a pair in packed mode)
  // SEND  | sending the bytes of the captured pixel(s)
  // NEXT  | advance the pixel index or finish
  // TRAIL | sending the checksum byte
  // FIN   | done pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE, HDR, FETCH, SEND, NEXT,
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
    TRAIL,
`endif
    FIN
  } state_t;

  typedef enum logic [1:0] {HS_ISSUE, HS_ACK, HS_DONE} hs_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state_q;
  hs_t               hs_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [2:0]        lat_q;
  logic              fwait_q;
  logic              pair_q;
  logic [15:0]       pix0_q;
  logic [11:0]       pix1_q;
  logic [1:0]        mode_q;
  logic [1:0]        pmode_q;
  logic              busy_q;
  logic              done_q;
  logic              start_tx_q;
  logic [7:0]        tx_data_q;
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic [1:0]        eff_mode;
  logic [7:0]        cur_byte;
  logic [ADDR_W:0]   nxt1;
  logic [ADDR_W:0]   nxt2;
  logic              last_pix;

  assign nxt1     = {1'b0, idx_q} + (ADDR_W+1)'(1);
  assign nxt2     = {1'b0, idx_q} + (ADDR_W+1)'(2);
  assign last_pix = (pmode_q == 2'd2) ? (nxt2 >= DEPTH_W) : (nxt1 >= DEPTH_W);

  // Packed mode only exists for 12-bit pixels; otherwise fall back to two bytes per pixel.
  always_comb begin
    eff_mode = bus.mode;
    if (bus.mode == 2'd3) eff_mode = 2'd0;
    else if (bus.mode == 2'd2 && PIX_W != 12) eff_mode = 2'd1;
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      HDR: begin
        case (byte_idx_q)
          2'd0:    cur_byte = HDR0;
          2'd1:    cur_byte = HDR1;
          default: cur_byte = {6'b0, mode_q};
        endcase
      end
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
      TRAIL: cur_byte = csum_q;
`endif
      default: begin
        case (pmode_q)
          2'd1: cur_byte = (byte_idx_q == 2'd0) ? pix0_q[15:8] : pix0_q[7:0];
          2'd2: begin
            case (byte_idx_q)
              2'd0:    cur_byte = pix0_q[11:4];
              2'd1:    cur_byte = {pix0_q[3:0], pix1_q[11:8]};
              default: cur_byte = pix1_q[7:0];
            endcase
          end
          default: cur_byte = pix0_q[7:0];
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_db) begin
    if (!rst_db) begin
      state_q    <= IDLE;
      hs_q       <= HS_ISSUE;
      byte_idx_q <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      lat_q      <= '0;
      fwait_q    <= 1'b0;
      pair_q     <= 1'b0;
      pix0_q     <= '0;
      pix1_q     <= '0;
      mode_q     <= '0;
      pmode_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_tx_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      start_tx_q <= 1'b0;
      done_q     <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        // A byte already handed to uart_tx finishes on its own; we just let go.
        state_q   <= IDLE;
        hs_q      <= HS_ISSUE;
        busy_q    <= 1'b0;
        rd_addr_q <= '0;
        fwait_q   <= 1'b0;
        pair_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state_q    <= HDR;
              hs_q       <= HS_ISSUE;
              busy_q     <= 1'b1;
              idx_q      <= '0;
              byte_idx_q <= '0;
              mode_q     <= bus.mode;
              pmode_q    <= eff_mode;
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
              csum_q     <= '0;
`endif
            end
          end
          FETCH: begin
            if (!fwait_q) begin
              // Odd-depth packed tail: the missing partner pixel is zero, no read issued.
              if (pair_q && nxt1 >= DEPTH_W) begin
                pix1_q     <= '0;
                pair_q     <= 1'b0;
                byte_idx_q <= '0;
                state_q    <= SEND;
              end else begin
                rd_addr_q <= pair_q ? nxt1[ADDR_W-1:0] : idx_q;
                lat_q     <= 3'(RD_LAT);
                fwait_q   <= 1'b1;
              end
            end else if (lat_q != 3'd0) begin
              lat_q <= lat_q - 3'd1;
            end else begin
              fwait_q <= 1'b0;
              if (pair_q) pix1_q <= 12'(bus.rd_data);
              else        pix0_q <= 16'(bus.rd_data);
              if (pmode_q == 2'd2 && !pair_q) begin
                pair_q <= 1'b1;
              end else begin
                pair_q     <= 1'b0;
                byte_idx_q <= '0;
                state_q    <= SEND;
              end
            end
          end
          NEXT: begin
            if (last_pix) begin
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
              byte_idx_q <= '0;
              state_q    <= TRAIL;
`else
              done_q     <= 1'b1;
              state_q    <= FIN;
`endif
            end else begin
              idx_q   <= (pmode_q == 2'd2) ? nxt2[ADDR_W-1:0] : nxt1[ADDR_W-1:0];
              state_q <= FETCH;
            end
          end
          FIN: begin
            busy_q    <= 1'b0;
            rd_addr_q <= '0;
            state_q   <= IDLE;
          end
          default: begin
            case (hs_q)
              HS_ISSUE: begin
                if (!bus.tx_busy) begin
                  tx_data_q  <= cur_byte;
                  start_tx_q <= 1'b1;
                  hs_q       <= HS_ACK;
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
                  if (state_q == SEND) csum_q <= csum_q ^ cur_byte;
`endif
                end
              end
              HS_ACK: if (bus.tx_busy) hs_q <= HS_DONE;
              default: begin
                if (!bus.tx_busy) begin
                  hs_q       <= HS_ISSUE;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (state_q == HDR) begin
                    if (byte_idx_q == 2'd2) begin
                      fwait_q <= 1'b0;
                      pair_q  <= 1'b0;
                      state_q <= FETCH;
                    end
                  end else if (state_q == SEND) begin
                    if (byte_idx_q == pmode_q) state_q <= NEXT;
                  end
`ifdef FRAME_UART_STREAMER_CHECKSUM_EN
                  else if (state_q == TRAIL) begin
                    done_q  <= 1'b1;
                    state_q <= FIN;
                  end
`endif
                  else state_q <= IDLE;
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_req   = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.start_tx = start_tx_q;
endmodule

// File: doc/frame_uart_streamer.md
Name: frame_uart_streamer

Overview:
- Streams a frame buffer from a BRAM read port to the 8-bit uart_tx byte interface, framed with a header.
- Generalises the single-mode "lower byte per pixel" dump: parametrised depth, pixel width and BRAM read latency.
- Supports selectable packing modes and abort.
- Sits in the clk25 domain between the frame BRAM read port (muxed with VGA via rd_req) and uart_tx.

Parameters:
- PIX_W, 12, pixel width in bits (1..16).
- ADDR_W, 19, BRAM address width.
- DEPTH, 76800, pixels per frame; addresses 0..DEPTH-1.
- RD_LAT, 1, BRAM read latency in cycles from rd_addr to valid rd_data (1..4).
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.

Ports:
- clk  in  1  clock.
- rst_db  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse; begins a frame when idle.
- mode  in  2  packing mode, sampled only on an accepted start.
- abort  in  1  terminates the frame immediately.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  1-cycle pulse after the last byte's UART transfer completes.
- rd_req  out  1  high while the streamer owns the BRAM read port (equal to busy).
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  PIX_W  BRAM read data.
- tx_data  out  8  byte to uart_tx.
- start_tx  out  1  1-cycle request to uart_tx.
- tx_busy  in  1  uart_tx busy.

Behaviour:
- Reset values: busy 0, done 0, rd_req 0, rd_addr 0, tx_data 0, start_tx 0, FSM in IDLE.
- Modes, with mode latched at start:
  - 0: one byte per pixel, p[7:0].
  - 1: two bytes per pixel, MSB first, zero-padded to 16 bits.
  - 2: packed, PIX_W=12 only. A pixel pair p0,p1 gives three bytes: p0[11:4], {p0[3:0],p1[11:8]}, p1[7:0]. For odd DEPTH the last p1 is 0.
  - 3: treated as mode 0.
  - Mode 2 with PIX_W!=12 is treated as mode 1.
- Byte stream: HDR0, HDR1, {6'b0,latched_mode}, then the payload.
  - Payload length: DEPTH (mode 0), 2*DEPTH (mode 1), 3*ceil(DEPTH/2) (mode 2).
- FSM states:
  - IDLE: accepted start goes to HDR; pixel index cleared.
  - HDR: issues the 3 header bytes via the send handshake.
  - FETCH: rd_addr = pixel index. Waits RD_LAT cycles, then captures rd_data into a pixel register. In mode 2, fetches two pixels before going to SEND.
  - SEND: emits the bytes for the captured pixel(s) in order, each via the send handshake.
  - NEXT: if the last pixel has been sent go to TRAIL (CHECKSUM_EN) or FIN; else increment the index and go to FETCH.
  - TRAIL: only with CHECKSUM_EN; sends the checksum byte.
  - FIN: pulses done for 1 cycle, clears busy and rd_req, returns to IDLE.
- Send handshake for every byte:
  1. With tx_busy=0, drive tx_data and pulse start_tx for exactly 1 cycle.
  2. WAIT_ACK: wait for tx_busy=1.
  3. WAIT_DONE: wait for tx_busy=0.
  - tx_data holds its value until the next byte is issued.
  - start_tx is never asserted while tx_busy=1.
- rd_addr:
  - Changes only in FETCH; otherwise stable.
  - Returns to 0 in IDLE.
  - Never exceeds DEPTH-1; the mode-2 odd tail does not read address DEPTH.
- Boundaries:
  - start while busy: ignored; latched mode unchanged.
  - mode changes mid-frame: ignored.
  - abort in any non-IDLE state (including same cycle as start): next cycle returns to IDLE with busy=0, rd_req=0, start_tx=0, and no done pulse. A UART byte already in flight completes on its own.
  - abort in IDLE: no effect. Abort and start in the same IDLE cycle: abort wins, start ignored.
  - A new start after an abort restarts from the header at address 0.
  - Reset mid-frame: all outputs go to their reset values asynchronously.
  - DEPTH=1 is legal.

Optional Feature:
- Macro: FRAME_UART_STREAMER_CHECKSUM_EN.
- Defined:
  - Running 8-bit XOR of all payload bytes (header excluded), cleared on an accepted start.
  - Sent as one trailer byte after the payload; done follows its UART completion.
- Undefined:
  - No accumulator and no TRAIL state; done follows the last payload byte.

Test Plan:
- DEPTH=4, RD_LAT=1, mode 0, BRAM {123,456,789,ABC}h, uart model (tx_busy high 10 cycles, 1 cycle after start_tx) -> bytes A5 5A 00 23 56 89 BC; one done pulse; busy falls the cycle after done.
- Same data, mode 1 -> A5 5A 01 01 23 04 56 07 89 0A BC.
- DEPTH=3, mode 2, {123,456,789}h -> A5 5A 02 12 34 56 78 90 00; rd_addr never reaches 3.
- RD_LAT=3, mode 0 -> same bytes as the first scenario.
  - Every capture occurs 3 cycles after rd_addr settles.
  - No start_tx is asserted while tx_busy=1.
- Abort one cycle after the 4th start_tx -> no further start_tx, busy=0 next cycle, no done. A later start resends from A5 at address 0. A start pulsed mid-frame, or a mode change mid-frame, leaves the stream unchanged.
- With FRAME_UART_STREAMER_CHECKSUM_EN, first scenario -> trailer byte 40h (23^56^89^BC) after BC; done follows its UART completion.
